uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single UART `transmitter` among NUM_REQ byte producers.
- Accepts bytes over per-requester valid/ready handshakes and drives `trans_data` and a one-cycle `tran_start` into the transmitter.
- Tracks `tx_busy` through each frame.
- Supports packet locking via `req_last`, so a multi-byte message from one requester is never interleaved with another's.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the sequencer state encoding and default widths/timeouts.
package uart_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int BUSY_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req at or after ptr.
// Ports: req (request vector), ptr (start index), found, index (winner).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [2*N-1:0] dbl;
  logic [IW:0]    sum;

  always_comb begin
    found = 1'b0;
    index = '0;
    sum   = '0;
    // Rotate so bit 0 is the requester at ptr.
    dbl   = {req, req} >> ptr;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N))
        sum = sum - (IW+1)'(N);
      if (!found && dbl[k]) begin
        found = 1'b1;
        index = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ
// producers. Ports: clk, rst (sync, active high); req_valid/req_data/
// req_last/req_ready (per-requester handshake); trans_data, tran_start,
// tx_busy (transmitter side); grant_valid, grant_id, err_timeout (status).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         trans_data,
  output logic                      tran_start,
  input  logic                      tx_busy,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  state_t            state, state_n;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_n;
  logic [ID_W-1:0]   owner, owner_n;
  logic [ID_W-1:0]   owner_inc;
  logic [ID_W-1:0]   grant_id_n;
  logic [ID_W-1:0]   pick_idx, win;
  logic              pick_found, accept;
  logic              lock, lock_n;
  logic              grant_valid_n;
  logic [DATA_W-1:0] trans_data_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  assign owner_inc = (owner == LAST_ID) ? '0 : owner + 1'b1;

  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    owner_n       = owner;
    lock_n        = lock;
    cnt_n         = cnt;
    trans_data_n  = trans_data;
    grant_id_n    = grant_id;
    grant_valid_n = grant_valid;
    req_ready     = '0;
    tran_start    = 1'b0;
    err_timeout   = 1'b0;
    win           = owner;
    accept        = 1'b0;

    unique case (state)
      IDLE: begin
        if (!tx_busy) begin
          // A held lock pins the grant to the packet owner.
          if (lock) begin
            win    = owner;
            accept = req_valid[owner];
          end else begin
            win    = pick_idx;
            accept = pick_found;
          end
          if (accept) begin
            req_ready[win] = 1'b1;
            trans_data_n   = req_data[win*DATA_W +: DATA_W];
            owner_n        = win;
            grant_id_n     = win;
            grant_valid_n  = 1'b1;
            lock_n         = ~req_last[win];
            state_n        = START;
          end
        end
      end
      START: begin
        tran_start = 1'b1;
        cnt_n      = '0;
        state_n    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else if (cnt == CNT_MAX) begin
          // Transmitter never answered: drop the packet lock.
          err_timeout   = 1'b1;
          lock_n        = 1'b0;
          rr_ptr_n      = owner_inc;
          grant_valid_n = 1'b0;
          state_n       = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_n = IDLE;
          if (!lock) begin
            rr_ptr_n      = owner_inc;
            grant_valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // No handshake or pulse may escape while reset is applied.
    if (rst) begin
      req_ready   = '0;
      tran_start  = 1'b0;
      err_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      lock        <= 1'b0;
      cnt         <= '0;
      trans_data  <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      owner       <= owner_n;
      lock        <= lock_n;
      cnt         <= cnt_n;
      trans_data  <= trans_data_n;
      grant_id    <= grant_id_n;
      grant_valid <= grant_valid_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model,
// stub transmitter, per-requester byte sources and directed scenarios.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TO  = 64;
  localparam int IW  = 2;
  localparam int LEN = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]  trans_data;
  logic          tran_start, tx_busy, grant_valid, err_timeout;
  logic [IW-1:0] grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .DATA_W       (W),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .trans_data  (trans_data),
    .tran_start  (tran_start),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  // Byte sources: written by the stimulus, consumed on valid&ready.
  logic [W-1:0] src_d [N][16];
  logic         src_l [N][16];
  logic [4:0]   src_wr [N] = '{default: '0};
  logic [4:0]   src_rd [N] = '{default: '0};

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (src_rd[i] != src_wr[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = src_d[i][src_rd[i][3:0]];
        req_last[i]        = src_l[i][src_rd[i][3:0]];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i])
        src_rd[i] <= src_rd[i] + 5'd1;
  end

  // Stub transmitter: busy for LEN cycles after each start pulse.
  logic stub_en    = 1'b1;
  logic force_busy = 1'b0;
  logic stub_busy;
  int   stub_left;

  always @(posedge clk) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_left <= 0;
    end else if (stub_en && tran_start) begin
      stub_busy <= 1'b1;
      stub_left <= LEN;
    end else if (stub_left > 1) begin
      stub_left <= stub_left - 1;
    end else begin
      stub_busy <= 1'b0;
      stub_left <= 0;
    end
  end

  assign tx_busy = stub_busy | force_busy;

  // Hand-computed frame list: byte and grant id expected per start pulse.
  logic [W-1:0]  lit_b [32];
  logic [IW-1:0] lit_g [32];
  int            exp_wr = 0;
  int            exp_rd = 0;
  logic          hang     = 1'b0;
  logic          fin_req  = 1'b0;
  logic          fin_done = 1'b0;

  // Model state: frame in flight, packet owner, lock, rotation pointer.
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  int            ts_cyc = 0;
  int            m_rr, m_owner, m_since;
  logic          m_lock, m_gv, m_infl, m_pend, m_seen;
  logic [IW-1:0] m_gid;
  logic [W-1:0]  m_data;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    logic         e_err, fin_to, fin_ok;
    int           w, j;
    cyc++;
    if (rst) begin
      chk("ready_in_rst", 32'(req_ready), 0);
      chk("start_in_rst", 32'(tran_start), 0);
      m_rr = 0; m_owner = 0; m_since = 0;
      m_lock = 0; m_gv = 0; m_infl = 0; m_pend = 0; m_seen = 0;
      m_gid = '0; m_data = '0;
    end else begin
      e_ready = '0;
      e_err   = 1'b0;
      fin_to  = 1'b0;
      fin_ok  = 1'b0;
      w       = -1;
      if (!m_infl && !tx_busy) begin
        if (m_lock) begin
          if (req_valid[IW'(m_owner)]) w = m_owner;
        end else begin
          for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (w < 0 && req_valid[IW'(j)]) w = j;
          end
        end
        if (w >= 0) e_ready[IW'(w)] = 1'b1;
      end
      if (m_infl && !m_pend) begin
        m_since++;
        if (!m_seen) begin
          if (tx_busy) m_seen = 1'b1;
          else if (m_since == TO) begin
            e_err  = 1'b1;
            fin_to = 1'b1;
          end
        end else if (!tx_busy) begin
          fin_ok = 1'b1;
        end
      end

      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("tran_start", 32'(tran_start), 32'(m_pend));
      chk("err_timeout", 32'(err_timeout), 32'(e_err));
      chk("grant_valid", 32'(grant_valid), 32'(m_gv));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("trans_data", 32'(trans_data), 32'(m_data));

      if (tran_start) begin
        ts_cyc = cyc;
        if (exp_rd < exp_wr) begin
          chk("lit_byte", 32'(trans_data), 32'(lit_b[exp_rd]));
          chk("lit_gid", 32'(grant_id), 32'(lit_g[exp_rd]));
          exp_rd++;
        end else begin
          chk("lit_extra_start", 32'(tran_start), 0);
        end
      end
      if (err_timeout)
        chk("timeout_distance", 32'(cyc - ts_cyc), 32'd64);

      if (fin_to) begin
        m_infl = 0; m_lock = 0; m_gv = 0;
        m_rr = (m_owner + 1) % N;
      end
      if (fin_ok) begin
        m_infl = 0;
        if (!m_lock) begin
          m_gv = 0;
          m_rr = (m_owner + 1) % N;
        end
      end
      if (m_pend) begin
        m_pend = 0; m_since = 0; m_seen = 0;
      end
      if (w >= 0) begin
        m_data  = req_data[w*W +: W];
        m_owner = w;
        m_gid   = IW'(w);
        m_gv    = 1'b1;
        m_lock  = ~req_last[IW'(w)];
        m_infl  = 1'b1;
        m_pend  = 1'b1;
      end
    end
    if (fin_req && !fin_done) begin
      chk("all_frames_seen", 32'(exp_rd), 32'(exp_wr));
      chk("no_hang", 32'(hang), 0);
      fin_done = 1'b1;
    end
  end

  task automatic push(input int r, input logic [W-1:0] d, input logic l);
    src_d[r][src_wr[r][3:0]] = d;
    src_l[r][src_wr[r][3:0]] = l;
    src_wr[r] = src_wr[r] + 5'd1;
  endtask

  task automatic expect_frame(input logic [W-1:0] d, input logic [IW-1:0] g);
    lit_b[exp_wr] = d;
    lit_g[exp_wr] = g;
    exp_wr++;
  endtask

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < N; i++)
      if (src_rd[i] != src_wr[i]) p = 1'b1;
    return p;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((pending() || m_infl) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) hang = 1'b1;
    cycles(2);
  endtask

  initial begin
    int n;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Single byte from requester 2.
    expect_frame(8'hA5, 2'd2);
    push(2, 8'hA5, 1'b1);
    wait_drain();

    // Pointer now at 3: requester 3 goes before 0.
    expect_frame(8'hB3, 2'd3);
    expect_frame(8'hB0, 2'd0);
    push(0, 8'hB0, 1'b1);
    push(3, 8'hB3, 1'b1);
    wait_drain();

    // Foreign busy in IDLE holds off the accept.
    force_busy = 1'b1;
    expect_frame(8'h77, 2'd2);
    push(2, 8'h77, 1'b1);
    cycles(10);
    force_busy = 1'b0;
    wait_drain();

    // Locked three-byte packet with a gap; requester 0 waits.
    expect_frame(8'h3C, 2'd1);
    expect_frame(8'h5A, 2'd1);
    expect_frame(8'h7E, 2'd1);
    expect_frame(8'h99, 2'd0);
    push(1, 8'h3C, 1'b0);
    push(1, 8'h5A, 1'b0);
    cycles(3);
    push(0, 8'h99, 1'b1);
    cycles(40);
    push(1, 8'h7E, 1'b1);
    wait_drain();

    // Dead transmitter: timeout, then requester 1 still served.
    stub_en = 1'b0;
    expect_frame(8'h55, 2'd0);
    push(0, 8'h55, 1'b1);
    wait_drain();
    stub_en = 1'b1;
    expect_frame(8'h66, 2'd1);
    push(1, 8'h66, 1'b1);
    wait_drain();

    // Reset during a locked frame; stalled owner loses to requester 3.
    expect_frame(8'h10, 2'd0);
    push(0, 8'h10, 1'b0);
    n = 0;
    while (!tx_busy && n < 50) begin
      cycles(1);
      n++;
    end
    if (n >= 50) hang = 1'b1;
    cycles(1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    expect_frame(8'hC3, 2'd3);
    push(3, 8'hC3, 1'b1);
    wait_drain();

    // Four-way contention from pointer 0.
    expect_frame(8'h11, 2'd0);
    expect_frame(8'h22, 2'd1);
    expect_frame(8'h33, 2'd2);
    expect_frame(8'h44, 2'd3);
    push(0, 8'h11, 1'b1);
    push(1, 8'h22, 1'b1);
    push(2, 8'h33, 1'b1);
    push(3, 8'h44, 1'b1);
    wait_drain();

    fin_req = 1'b1;
    repeat (3) @(negedge clk);
    if (!fin_done) begin
      $display("FAIL final_check: not reached");
      $fatal(1, "final check not reached");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
